// File: rtl/fifo_mac_ctrl.sv
`default_nettype none
// fifo_mac_ctrl: drains DEPTH operand pairs in lockstep from two registered-read
// FIFOs and accumulates their unsigned products, pulsing done at the end of a run.
module fifo_mac_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  a_empty,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_rden,
  output logic                  b_rden,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  busy,
  output logic                  done
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          issue_cnt, acc_cnt;
  logic                      rd_valid;
  logic                      rden;
  logic                      start_run;
  logic [2*DATA_WIDTH-1:0]   product;

  assign product = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};

  always_comb begin
    state_nxt = state;
    rden      = 1'b0;
    start_run = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_run = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        rden = (issue_cnt < DEPTH_C) && !a_empty && !b_empty;
        if (rden && (issue_cnt == LAST_C))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        // The last pair's data lands one edge after its read; finish on that accumulate.
        if (rd_valid && (acc_cnt == LAST_C))
          state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      rd_valid  <= 1'b0;
      acc_out   <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= rden;
      if (start_run) begin
        issue_cnt <= '0;
        acc_cnt   <= '0;
        acc_out   <= '0;
      end else begin
        if (rden)
          issue_cnt <= issue_cnt + 1'b1;
        if (rd_valid) begin
          acc_out <= acc_out + ACC_WIDTH'(product);
          acc_cnt <= acc_cnt + 1'b1;
        end
      end
    end
  end

  assign a_rden = rden;
  assign b_rden = rden;
  assign busy   = (state == RUN) || (state == DRAIN);
  assign done   = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_mac_ctrl.sv
`default_nettype none
// tb_fifo_mac_ctrl: queue-based FIFO models feed the DUT; expected sums are queued
// at start and compared by a monitor whenever done is presented.
module tb_fifo_mac_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 16;

  typedef logic [DW-1:0] ops_t [DEPTH];

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          a_empty = 1'b1, b_empty = 1'b1;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_rden, b_rden, busy, done;
  logic [AW-1:0] acc_out;

  fifo_mac_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_empty(a_empty), .b_empty(b_empty),
    .a_data(a_data), .b_data(b_data),
    .a_rden(a_rden), .b_rden(b_rden),
    .acc_out(acc_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO models with registered read data and registered empty flags
  logic [DW-1:0] qa[$], qb[$];
  logic          a_push = 1'b0, b_push = 1'b0;
  logic [DW-1:0] a_push_val = '0, b_push_val = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      a_data  <= '0;
      b_data  <= '0;
      a_empty <= 1'b1;
      b_empty <= 1'b1;
    end else begin
      if (a_rden && qa.size() > 0) a_data <= qa.pop_front();
      if (b_rden && qb.size() > 0) b_data <= qb.pop_front();
      if (a_push) qa.push_back(a_push_val);
      if (b_push) qb.push_back(b_push_val);
      a_empty <= (qa.size() == 0);
      b_empty <= (qb.size() == 0);
    end
  end

  // Feeder: per_x = N pushes every N cycles, 0 pushes with probability 1/2
  logic [DW-1:0] pa[$], pb[$];
  int per_a = 1, per_b = 1;

  initial forever begin
    @(negedge clk);
    a_push = 1'b0;
    b_push = 1'b0;
    if (rst_n && pa.size() > 0 &&
        ((per_a == 0) ? ($urandom_range(0, 1) == 0) : ((cyc % per_a) == 0))) begin
      a_push     = 1'b1;
      a_push_val = pa.pop_front();
    end
    if (rst_n && pb.size() > 0 &&
        ((per_b == 0) ? ($urandom_range(0, 1) == 0) : ((cyc % per_b) == 0))) begin
      b_push     = 1'b1;
      b_push_val = pb.pop_front();
    end
  end

  // Scoreboard monitor
  logic [AW-1:0] sb[$];
  int   done_cnt = 0, rden_cnt = 0, done_cyc = 0;
  logic prev_done = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (a_rden || b_rden) begin
        rden_cnt++;
        check("rden_aligned", a_rden, b_rden);
        check("rden_while_empty", a_empty | b_empty, 0);
      end
      if (done) begin
        check("done_single_cycle", prev_done, 0);
        check("busy_in_done", busy, 0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done seen with acc_out=%0d, expected no done", acc_out);
        end else begin
          check("acc_result", acc_out, sb.pop_front());
        end
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = done;
    end
  end

  function automatic logic [AW-1:0] ref_sum(input ops_t x, input ops_t y);
    longint s = 0;
    for (int i = 0; i < DEPTH; i++) s += longint'(x[i]) * longint'(y[i]);
    return AW'(s % (longint'(1) << AW));
  endfunction

  task automatic enqueue(input ops_t x, input ops_t y);
    for (int i = 0; i < DEPTH; i++) begin
      pa.push_back(x[i]);
      pb.push_back(y[i]);
    end
  endtask

  task automatic wait_fed();
    int k = 0;
    while ((pa.size() > 0 || pb.size() > 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL feed_timeout: %0d entries left, expected 0", pa.size() + pb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  int start_cyc = 0, rden0 = 0;

  task automatic start_run(input logic [AW-1:0] exp);
    @(negedge clk);
    start = 1'b1;
    sb.push_back(exp);
    start_cyc = cyc + 1;
    rden0     = rden_cnt;
    @(negedge clk);
    start = 1'b0;
    check("acc_clear_at_start", acc_out, 0);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: done not seen within 600 cycles, expected a done pulse");
    end else begin
      check("rden_count", rden_cnt - rden0, DEPTH);
    end
  endtask

  ops_t x, y, twos, ffs;
  logic [AW-1:0] exp_v;
  int   dc;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      twos[i] = DW'(2);
      ffs[i]  = DW'(8'hFF);
    end
    #2 rst_n = 1'b0;
    #1;
    check("reset_acc", acc_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_a_rden", a_rden, 0);
    check("reset_b_rden", b_rden, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-speed run, operands 1..8
    for (int i = 0; i < DEPTH; i++) x[i] = DW'(i + 1);
    enqueue(x, x);
    wait_fed();
    exp_v = ref_sum(x, x);
    start_run(exp_v);
    wait_done();
    check("full_speed_latency", cyc - start_cyc, DEPTH + 1);
    @(negedge clk);
    check("acc_holds_after_done", acc_out, exp_v);
    check("idle_after_done", busy, 0);

    // Stall: A preloaded, B trickles in every 3 cycles
    for (int i = 0; i < DEPTH; i++) begin
      x[i] = DW'($urandom);
      y[i] = DW'($urandom);
      pa.push_back(x[i]);
    end
    wait_fed();
    per_b = 3;
    for (int i = 0; i < DEPTH; i++) pb.push_back(y[i]);
    start_run(ref_sum(x, y));
    wait_done();
    per_b = 1;

    // All-ones operands: accumulator wraps
    enqueue(ffs, ffs);
    wait_fed();
    start_run(ref_sum(ffs, ffs));
    wait_done();

    // Starts during RUN and during DONE are ignored
    for (int i = 0; i < DEPTH; i++) begin
      x[i] = DW'($urandom);
      y[i] = DW'($urandom);
    end
    enqueue(x, y);
    wait_fed();
    exp_v = ref_sum(x, y);
    start_run(exp_v);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    dc = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignored_start_busy", busy, 0);
    check("ignored_start_acc", acc_out, exp_v);
    check("ignored_start_done_count", done_cnt, dc);

    // Back-to-back: second start one cycle after done, operands all 2
    for (int i = 0; i < DEPTH; i++) begin
      x[i] = DW'($urandom);
      y[i] = DW'($urandom);
    end
    enqueue(x, y);
    enqueue(twos, twos);
    wait_fed();
    start_run(ref_sum(x, y));
    wait_done();
    start_run(ref_sum(twos, twos));
    wait_done();
    check("back_to_back_latency", cyc - start_cyc, DEPTH + 1);

    // Random runs with random arrival on both FIFOs
    per_a = 0;
    per_b = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        x[i] = DW'($urandom);
        y[i] = DW'($urandom);
      end
      enqueue(x, y);
      start_run(ref_sum(x, y));
      wait_done();
    end
    per_a = 1;
    per_b = 1;

    // Asynchronous reset in the middle of a run
    for (int i = 0; i < DEPTH; i++) begin
      x[i] = DW'($urandom_range(1, 255));
      y[i] = DW'($urandom_range(1, 255));
    end
    enqueue(x, y);
    wait_fed();
    start_run(ref_sum(x, y));
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_acc", acc_out, 0);
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_a_rden", a_rden, 0);
    check("midrun_reset_b_rden", b_rden, 0);
    sb.delete();
    pa.delete();
    pb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Recovery run after reset
    enqueue(twos, x);
    wait_fed();
    start_run(ref_sum(twos, x));
    wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
